linear_fc_engine: RTL
=====================

Name: linear_fc_engine

Overview:
- Parametrised fully-connected layer engine for the KWS inference datapath. Computes y[o] = sat(bias[o] + sum_i x[i]*W[o][i]) for o = 0..OUT_DIM-1 on signed Q(DATA_W-FRAC_W).FRAC_W data.
- Sits after CMVN (first layer) or after ReLU (hidden layers). Buffers the full input vector, runs one MAC per cycle, and streams results with a valid/ready handshake.
- Weights and biases are runtime-loadable.

Parameters:
- DATA_W, 32: data, weight and bias width (signed, default Q7.24).
- FRAC_W, 24: fractional bits.
- IN_DIM, 40: input vector length.
- OUT_DIM, 10: output vector length.
- ACC_W, 2*DATA_W+8: accumulator width; must be >= 2*DATA_W+clog2(IN_DIM).

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: synchronous active-low reset.
- start, in, 1: begin a new vector; sampled in IDLE only.
- src_sel, in, 1: 0 = cmvn source, 1 = relu source; latched on start.
- cmvn_data, in, DATA_W: CMVN-stage input sample.
- relu_data, in, DATA_W: ReLU-stage input sample.
- in_valid, in, 1: selected source sample valid.
- in_ready, out, 1: engine accepts sample (LOAD only).
- wt_wr_en, in, 1: weight/bias write strobe.
- wt_wr_bias, in, 1: 1 = write bias[wt_wr_addr], 0 = write weight[wt_wr_addr].
- wt_wr_addr, in, clog2(OUT_DIM*IN_DIM): weight index o*IN_DIM+i, or bias index o.
- wt_wr_data, in, DATA_W: write data.
- out_data, out, DATA_W: saturated result.
- out_addr, out, clog2(OUT_DIM): output index o.
- out_valid, out, 1: result valid.
- out_ready, in, 1: downstream accepts.
- busy, out, 1: high in any state other than IDLE.
- done, out, 1: one-cycle pulse after the last output handshake.
- sat_flag, out, 1: sticky; set when any output saturated; cleared on start.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; in_ready, out_valid, done, busy, sat_flag = 0; out_data=0; out_addr=0; counters=0. Weight, bias and input buffers are not reset. Reset mid-operation aborts immediately with no partial output.
- States: IDLE -> LOAD -> MAC -> OUT -> (MAC | FINISH) -> IDLE.
- IDLE: start=1 latches src_sel, clears sat_flag, sets in_cnt=0 -> LOAD. wt_wr_en is honoured only in IDLE; writes in other states are ignored. start outside IDLE is ignored.
- LOAD: in_ready=1. Each cycle with in_valid&&in_ready, the selected source is written to xbuf[in_cnt] and in_cnt increments. After the transfer with in_cnt==IN_DIM-1 -> MAC, with o=0, i=0, acc=0. Samples arrive in index order; no address port.
- MAC: registered weight/xbuf read, 1-cycle pipeline. Issue i=0..IN_DIM-1 on consecutive cycles, plus 1 drain cycle, so IN_DIM+1 cycles per output.
  - Product: full 2*DATA_W signed, sign-extended into ACC_W, accumulated without truncation.
  - After drain: r = (acc >>> FRAC_W) + sign_ext(bias[o]), using arithmetic shift (floor).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; set sat_flag if clipped.
  - Register out_data, set out_addr=o, out_valid=1 -> OUT.
- OUT: out_valid held, data and addr stable until out_ready=1. On handshake: out_valid=0; if o==OUT_DIM-1 -> FINISH, else o++, acc=0 -> MAC. If out_ready is already high, the handshake completes in the first OUT cycle.
- FINISH: done=1 for one cycle -> IDLE. busy falls in the same cycle IDLE is entered.
- Latency: start to first out_valid = 1 + IN_DIM (zero-stall input) + IN_DIM+1 cycles.
- Simultaneous start and wt_wr_en in IDLE: the write is performed and start is also taken.

Optional Feature:
- Macro LINEAR_FC_RELU_EN.
- Defined: fused ReLU after saturation; negative results are emitted as 0, and sat_flag logic is unchanged (evaluated before ReLU).
- Undefined: signed saturated result is emitted as-is.

Test Plan:
- IN_DIM=4, OUT_DIM=2, bias=0. x=[1.0,2.0,-1.0,0.5]; W row0=[1.5,0.75,0.25,1.0]; row1=[-1.0,0,0,0]. Expect out0=0x03400000 (3.25), addr 0; out1=0xFF000000 (-1.0), addr 1; then done pulse; sat_flag=0.
- Same vectors with bias0=0x00800000 (0.5): out0=0x03C00000 (3.75). Weight write attempted while busy: the stored weight is unchanged on the next run.
- x[0]=100.0 (0x64000000), W[0][0]=100.0, others 0: out0=0x7FFFFFFF, sat_flag=1. Value -100.0 gives 0x80000000. With LINEAR_FC_RELU_EN, out1=0 and out0 is unchanged.
- Back-pressure: hold out_ready=0 for 5 cycles with out_valid=1. out_data and out_addr stay stable; accept on cycle 6; next output follows IN_DIM+1 cycles later.
- in_valid toggled 1,0,1,0 on src_sel=1: only relu_data is captured (cmvn_data driven 0xDEADBEEF is ignored); result matches the reference model.
- rst_n=0 for one cycle mid-MAC: next cycle busy=0, out_valid=0. A new start then produces correct results with previously loaded weights intact.

Source files
------------

// File: rtl/linear_fc_engine_if.sv
// ---------------------------------------------------------------------------
// linear_fc_engine_if
//   Bundles every non-clock/reset signal of the linear_fc_engine: control
//   (start/src_sel/busy/done/sat_flag), the input sample stream, the
//   weight/bias write port and the output result stream.
//
//   Modports:
//     slave  - the engine itself
//     master - the surrounding datapath / controller driving the engine
//
//   Parameters must match those of the engine instance it connects to.
// ---------------------------------------------------------------------------
interface linear_fc_engine_if #(
  parameter int DATA_W  = 32,
  parameter int IN_DIM  = 40,
  parameter int OUT_DIM = 10
);
  localparam int WA_W = (OUT_DIM * IN_DIM > 1) ? $clog2(OUT_DIM * IN_DIM) : 1;
  localparam int OA_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  // Control / status
  logic              start;
  logic              src_sel;
  logic              busy;
  logic              done;
  logic              sat_flag;

  // Input sample stream (two candidate sources, one valid/ready pair)
  logic [DATA_W-1:0] cmvn_data;
  logic [DATA_W-1:0] relu_data;
  logic              in_valid;
  logic              in_ready;

  // Weight / bias write port
  logic              wt_wr_en;
  logic              wt_wr_bias;
  logic [WA_W-1:0]   wt_wr_addr;
  logic [DATA_W-1:0] wt_wr_data;

  // Output result stream
  logic [DATA_W-1:0] out_data;
  logic [OA_W-1:0]   out_addr;
  logic              out_valid;
  logic              out_ready;

  modport slave (
    input  start, src_sel, cmvn_data, relu_data, in_valid,
           wt_wr_en, wt_wr_bias, wt_wr_addr, wt_wr_data, out_ready,
    output in_ready, out_data, out_addr, out_valid, busy, done, sat_flag
  );

  modport master (
    output start, src_sel, cmvn_data, relu_data, in_valid,
           wt_wr_en, wt_wr_bias, wt_wr_addr, wt_wr_data, out_ready,
    input  in_ready, out_data, out_addr, out_valid, busy, done, sat_flag
  );
endinterface

// File: rtl/linear_fc_engine.sv
// ---------------------------------------------------------------------------
// linear_fc_engine
//   Fully-connected layer for the KWS inference datapath:
//     y[o] = sat(bias[o] + sum_i x[i] * W[o][i]),  o = 0..OUT_DIM-1
//   on signed fixed point with FRAC_W fractional bits.
//
//   Flow: IDLE -> LOAD (buffer IN_DIM samples) -> MAC (IN_DIM issue cycles +
//   1 drain cycle per output) -> OUT (hold until out_ready) -> MAC or
//   FINISH (one-cycle done) -> IDLE.
//
//   Ports:
//     clk    - clock
//     rst_n  - synchronous active-low reset
//     bus    - linear_fc_engine_if.slave: start/src_sel, cmvn/relu sample
//              stream (in_valid/in_ready), weight/bias write port (honoured
//              in IDLE only), result stream (out_data/out_addr/out_valid/
//              out_ready), busy, done, sticky sat_flag.
//
//   Build option:
//     LINEAR_FC_RELU_EN - when defined, negative saturated results are
//                         emitted as 0 (sat_flag is evaluated before ReLU).
//
//   ACC_W must be >= 2*DATA_W + clog2(IN_DIM) so the accumulator never wraps.
// ---------------------------------------------------------------------------
module linear_fc_engine #(
  parameter int DATA_W  = 32,
  parameter int FRAC_W  = 24,
  parameter int IN_DIM  = 40,
  parameter int OUT_DIM = 10,
  parameter int ACC_W   = 2 * DATA_W + 8
) (
  input logic               clk,
  input logic               rst_n,
  linear_fc_engine_if.slave bus
);

  localparam int WA_W = (OUT_DIM * IN_DIM > 1) ? $clog2(OUT_DIM * IN_DIM) : 1;
  localparam int OA_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int IX_W = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int MI_W = $clog2(IN_DIM + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_MAC    = 3'd2;
  localparam logic [2:0] S_OUT    = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  // Saturation bounds of a DATA_W signed result, expressed at accumulator width.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  // Storage
  logic signed [DATA_W-1:0] wmem [OUT_DIM * IN_DIM];
  logic signed [DATA_W-1:0] bmem [OUT_DIM];
  logic signed [DATA_W-1:0] xbuf [IN_DIM];

  // Control state
  logic [2:0]              state;
  logic                    src_q;
  logic [IX_W-1:0]         in_cnt;
  logic [MI_W-1:0]         mac_i;
  logic [OA_W-1:0]         o_cnt;
  logic signed [ACC_W-1:0] acc;
  logic                    p_vld;       // w_q/x_q hold a product to accumulate
  logic signed [DATA_W-1:0] w_q;
  logic signed [DATA_W-1:0] x_q;
  logic [DATA_W-1:0]       out_data_q;
  logic [OA_W-1:0]         out_addr_q;
  logic                    out_valid_q;
  logic                    sat_q;

  // Datapath
  logic                      mac_issue;
  logic                      mac_drain;
  logic [WA_W-1:0]           w_rd_addr;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   res_full;
  logic [DATA_W-1:0]         res_sat;
  logic [DATA_W-1:0]         res_out;
  logic                      clip;

  assign mac_issue = (state == S_MAC) && (mac_i < MI_W'(IN_DIM));
  assign mac_drain = (state == S_MAC) && (mac_i == MI_W'(IN_DIM));
  assign w_rd_addr = WA_W'(int'(o_cnt) * IN_DIM + int'(mac_i));

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    prod     = (2*DATA_W)'(w_q) * (2*DATA_W)'(x_q);
    prod_ext = ACC_W'(prod);
    acc_sum  = p_vld ? acc + prod_ext : acc;
    bias_ext = ACC_W'(bmem[o_cnt]);
    // Arithmetic shift floors toward -inf, matching the fixed-point rule.
    res_full = (acc_sum >>> FRAC_W) + bias_ext;
    res_sat  = res_full[DATA_W-1:0];
    clip     = 1'b0;
    if (res_full > SAT_MAX) begin
      res_sat = {1'b0, {(DATA_W - 1){1'b1}}};
      clip    = 1'b1;
    end else if (res_full < SAT_MIN) begin
      res_sat = {1'b1, {(DATA_W - 1){1'b0}}};
      clip    = 1'b1;
    end
`ifdef LINEAR_FC_RELU_EN
    res_out = res_sat[DATA_W-1] ? '0 : res_sat;
`else
    res_out = res_sat;
`endif
  end

  // Control FSM and result registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      src_q       <= 1'b0;
      in_cnt      <= '0;
      mac_i       <= '0;
      o_cnt       <= '0;
      acc         <= '0;
      p_vld       <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      p_vld <= mac_issue;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            src_q  <= bus.src_sel;
            sat_q  <= 1'b0;
            in_cnt <= '0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (bus.in_valid) begin
            in_cnt <= in_cnt + IX_W'(1);
            if (in_cnt == IX_W'(IN_DIM - 1)) begin
              mac_i <= '0;
              o_cnt <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_MAC: begin
          acc <= acc_sum;
          if (mac_drain) begin
            out_data_q  <= res_out;
            out_addr_q  <= o_cnt;
            out_valid_q <= 1'b1;
            if (clip) sat_q <= 1'b1;
            state       <= S_OUT;
          end else begin
            mac_i <= mac_i + MI_W'(1);
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (o_cnt == OA_W'(OUT_DIM - 1)) begin
              state <= S_FINISH;
            end else begin
              o_cnt <= o_cnt + OA_W'(1);
              mac_i <= '0;
              acc   <= '0;
              state <= S_MAC;
            end
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Weight/bias/input buffers and the registered operand read.
  // NOTE: storage arrays are deliberately left out of reset; their contents
  // survive rst_n and a reset mid-run only discards the control state.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && bus.wt_wr_en) begin
      if (bus.wt_wr_bias) begin
        if (int'(bus.wt_wr_addr) < OUT_DIM) bmem[bus.wt_wr_addr[OA_W-1:0]] <= bus.wt_wr_data;
      end else begin
        if (int'(bus.wt_wr_addr) < OUT_DIM * IN_DIM) wmem[bus.wt_wr_addr] <= bus.wt_wr_data;
      end
    end
    if (state == S_LOAD && bus.in_valid) begin
      xbuf[in_cnt] <= src_q ? bus.relu_data : bus.cmvn_data;
    end
    if (mac_issue) begin
      w_q <= wmem[w_rd_addr];
      x_q <= xbuf[mac_i[IX_W-1:0]];
    end
  end

  assign bus.in_ready  = (state == S_LOAD);
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = (state == S_FINISH);
  assign bus.out_data  = out_data_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sat_flag  = sat_q;

endmodule
